// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width
// for the bit-serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : arith_pkg

// File: rtl/fsub_cell.sv
// Combinational 1-bit full subtractor: diff = x - y - bi, with borrow-out bo.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  logic xy_diff;

  assign xy_diff = x ^ y;
  assign diff    = xy_diff ^ bi;
  // Borrow when y exceeds x outright, or when they match and a borrow ripples in.
  assign bo      = (~x & y) | (~xy_diff & bi);

endmodule : fsub_cell

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock LSB first,
// built around a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor_8bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-2:0] res_sr_reg;
  logic [CW-1:0]    count_reg;
  logic             br_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bout_reg;
  logic             ovf_reg;

  logic             cell_diff;
  logic             cell_bo;
  logic [WIDTH-1:0] res_next;

  fsub_cell u_cell (
    .x    (a_sr_reg[0]),
    .y    (b_sr_reg[0]),
    .bi   (br_reg),
    .diff (cell_diff),
    .bo   (cell_bo)
  );

  // The result register only holds the upper WIDTH-1 bits; the bit being
  // produced this cycle completes the word, so the final edge can load d directly.
  assign res_next = {cell_diff, res_sr_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      count_reg  <= '0;
      br_reg     <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            br_reg     <= bin;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
            res_sr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        RUN: begin
          a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
          res_sr_reg <= res_next[WIDTH-1:1];
          br_reg     <= cell_bo;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            d_reg     <= res_next;
            bout_reg  <= cell_bo;
            // Signed overflow: operand signs differ and the result sign left the minuend's.
            ovf_reg   <= (a_msb_reg != b_msb_reg) && (cell_diff != a_msb_reg);
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign d    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule : serial_subtractor_8bit

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed cases plus random
// operations compared against an integer-arithmetic reference model.
module tb_serial_subtractor_8bit;

  localparam int W     = 8;
  localparam int BOUND = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction; ovf follows the sign-comparison rule.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    int diff;
    diff = int'(ma) - int'(mb) - int'(mbin);
    md   = W'(diff);
    mbo  = (diff < 0);
    mov  = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
  endfunction

  // Counts negedges after the accept edge until done; optionally pulses start
  // with junk operands at RUN cycle inj_cyc to show it is ignored.
  task automatic wait_done(input int inj_cyc, input bit keep_start, output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!done && cyc < BOUND) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == inj_cyc) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b0;
      end else if (!keep_start) begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                              input logic tbin, input int cyc, input bit busy_ok);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(ta, tb_v, tbin, ed, eb, eo);
    $display("op %s a=%02h b=%02h bin=%0d -> d=%02h bout=%0d ovf=%0d (exp %02h %0d %0d) lat=%0d",
             tag, ta, tb_v, tbin, d, bout, ovf, ed, eb, eo, cyc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_d"}, d, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tbin, input int inj_cyc);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    wait_done(inj_cyc, 1'b0, cyc, busy_ok);
    check_result(tag, ta, tb_v, tbin, cyc, busy_ok);
    @(negedge clk);
    check({tag, "_single_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    bit busy_ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    do_op("t1", 8'h05, 8'h03, 1'b0, -1);
    do_op("t2a", 8'h00, 8'h01, 1'b0, -1);
    do_op("t2b", 8'h10, 8'h0F, 1'b1, -1);
    do_op("t3a", 8'h80, 8'h01, 1'b0, -1);
    do_op("t3b", 8'h7F, 8'hFF, 1'b0, -1);
    do_op("eq_bin", 8'h3C, 8'h3C, 1'b1, -1);
    do_op("t4", 8'h05, 8'h03, 1'b0, 3);

    // Back-to-back: start held high, operands swapped during DONE.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(-1, 1'b1, cyc, busy_ok);
    check_result("t5a", 8'h05, 8'h03, 1'b0, cyc, busy_ok);
    a = 8'h20; b = 8'h01; bin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'h00; b = 8'h00;
    wait_done(-1, 1'b1, cyc, busy_ok);
    start = 1'b0;
    check_result("t5b", 8'h20, 8'h01, 1'b0, cyc, busy_ok);
    @(negedge clk);
    check("t5_single_pulse", done, 0);

    // Reset mid-operation: outputs clear asynchronously, no done follows.
    do_op("t6_pre", 8'h05, 8'h03, 1'b0, -1);
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_d", d, 0);
    check("t6_bout", bout, 0);
    check("t6_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    check("t6_no_activity", cyc, 0);
    do_op("t6_post", 8'h09, 8'h04, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      do_op("rnd", ra, rb, rbin, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor_8bit
